seg_scan_multi: RTL and testbench

- Parametrised time-multiplexed scanner for an N-digit seven-segment display; successor to the fixed two-digit scanner.
- Takes per-digit segment codes from the encoders and drives one shared segment bus plus a one-hot digit-select bus.
- Adds configurable digit count, dwell and blanking (anti-ghosting) times, output polarities, per-digit enable with skip, and a frame-done pulse for the display controller.

---
 rtl/seg_scan_pkg.sv | 32 +++
 rtl/seg_scan_multi_if.sv | 30 +++
 rtl/seg_scan_next_idx.sv | 33 +++
 rtl/seg_scan_multi.sv | 112 +++++++++++
 tb/tb_seg_scan_multi.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/seg_scan_pkg.sv
// Shared types and constant helpers for the multi-digit seven-segment scanner.
//   state_t      : scanner FSM encoding
//   idx_width()  : digit index width, never below 1
//   cnt_width()  : dwell/blank counter width
//   all_off()    : idle drive level for a bus, by polarity (buses up to 64 bits)
package seg_scan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_t;

  localparam int unsigned MAX_BUS_W = 64;

  function automatic int unsigned idx_width(input int unsigned num_digits);
    return (num_digits > 1) ? $clog2(num_digits) : 1;
  endfunction

  // Wide enough to hold the larger of the two terminal counts.
  function automatic int unsigned cnt_width(input int unsigned dwell, input int unsigned blank);
    int unsigned m;
    m = (dwell > blank) ? dwell : blank;
    return (m == 0) ? 1 : $clog2(m + 1);
  endfunction

  // Active-low buses idle high, active-high buses idle low.
  function automatic logic [MAX_BUS_W-1:0] all_off(input bit active_low);
    return active_low ? '1 : '0;
  endfunction

endpackage

// File: rtl/seg_scan_multi_if.sv
// Scanner bus: controller/encoder side (master) drives enables and codes,
// scanner side (slave) drives the display pins and frame status.
//   scan_en, digit_en, seg_data_in        : master -> slave
//   Seg_Out, Sel_Out, digit_idx, frame_done : slave -> master
interface seg_scan_multi_if
  import seg_scan_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 6,
  parameter int unsigned SEG_W      = 8
);
  localparam int unsigned IDX_W = idx_width(NUM_DIGITS);

  logic                        scan_en;
  logic [NUM_DIGITS-1:0]       digit_en;
  logic [NUM_DIGITS*SEG_W-1:0] seg_data_in;
  logic [SEG_W-1:0]            Seg_Out;
  logic [NUM_DIGITS-1:0]       Sel_Out;
  logic [IDX_W-1:0]            digit_idx;
  logic                        frame_done;

  modport master (
    output scan_en, digit_en, seg_data_in,
    input  Seg_Out, Sel_Out, digit_idx, frame_done
  );

  modport slave (
    input  scan_en, digit_en, seg_data_in,
    output Seg_Out, Sel_Out, digit_idx, frame_done
  );
endinterface

// File: rtl/seg_scan_next_idx.sv
// Rotating-priority search for the next enabled digit after cur_idx.
//   cur_idx  : digit shown most recently (search starts at cur_idx+1)
//   digit_en : per-digit enable
//   nxt_idx  : first enabled digit found circularly (cur_idx itself last)
//   any_en   : at least one digit enabled
//   wrapped  : search passed the top index (nxt_idx <= cur_idx)
module seg_scan_next_idx
  import seg_scan_pkg::*;
#(
  parameter  int unsigned NUM_DIGITS = 6,
  localparam int unsigned IDX_W      = idx_width(NUM_DIGITS)
) (
  input  logic [IDX_W-1:0]      cur_idx,
  input  logic [NUM_DIGITS-1:0] digit_en,
  output logic [IDX_W-1:0]      nxt_idx,
  output logic                  any_en,
  output logic                  wrapped
);

  // Scan farthest-first so the nearest enabled digit is the last one written.
  always_comb begin
    nxt_idx = cur_idx;
    any_en  = 1'b0;
    for (int k = NUM_DIGITS; k >= 1; k--) begin
      if (digit_en[IDX_W'((int'(cur_idx) + k) % NUM_DIGITS)]) begin
        nxt_idx = IDX_W'((int'(cur_idx) + k) % NUM_DIGITS);
        any_en  = 1'b1;
      end
    end
    wrapped = any_en && (nxt_idx <= cur_idx);
  end

endmodule

// File: rtl/seg_scan_multi.sv
// Time-multiplexed N-digit seven-segment scanner with blanking, skip and frame pulse.
//   CLK, RST : clock, synchronous active-high reset
//   bus      : seg_scan_multi_if slave (enables/codes in, Seg_Out/Sel_Out/digit_idx/frame_done out)
module seg_scan_multi
  import seg_scan_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 6,
  parameter int unsigned SEG_W          = 8,
  parameter int unsigned DWELL_CYCLES   = 499_999,
  parameter int unsigned BLANK_CYCLES   = 2_500,
  parameter bit          SEL_ACTIVE_LOW = 1'b1,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input logic             CLK,
  input logic             RST,
  seg_scan_multi_if.slave bus
);

  localparam int unsigned IDX_W      = idx_width(NUM_DIGITS);
  localparam int unsigned CW         = cnt_width(DWELL_CYCLES, BLANK_CYCLES);
  localparam bit          NO_BLANK   = (BLANK_CYCLES == 0);
  localparam int unsigned BLANK_LAST = NO_BLANK ? 0 : BLANK_CYCLES - 1;

  localparam logic [SEG_W-1:0]      SEG_OFF  = SEG_W'(all_off(SEG_ACTIVE_LOW));
  localparam logic [NUM_DIGITS-1:0] SEL_OFF  = NUM_DIGITS'(all_off(SEL_ACTIVE_LOW));
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  state_t                state;
  logic [CW-1:0]         cnt;
  logic [IDX_W-1:0]      idx_q;
  logic [SEG_W-1:0]      seg_q;
  logic [NUM_DIGITS-1:0] sel_q;
  logic                  fd_q;
  logic                  first_q;   // no advance has succeeded since IDLE

  logic [IDX_W-1:0]      nxt_idx;
  logic                  any_en;
  logic                  wrapped;
  logic [SEG_W-1:0]      codes [NUM_DIGITS];
  logic [SEG_W-1:0]      show_seg;
  logic [NUM_DIGITS-1:0] show_sel;
  logic                  show_last;
  logic                  blank_last;
  logic                  adv;

  seg_scan_next_idx #(
    .NUM_DIGITS (NUM_DIGITS)
  ) u_next_idx (
    .cur_idx  (idx_q),
    .digit_en (bus.digit_en),
    .nxt_idx  (nxt_idx),
    .any_en   (any_en),
    .wrapped  (wrapped)
  );

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_codes
    assign codes[g] = bus.seg_data_in[g*SEG_W +: SEG_W];
  end

  // Pin-level drive for the digit about to be shown; XOR with the idle level applies polarity.
  always_comb begin
    show_seg   = codes[nxt_idx] ^ SEG_OFF;
    show_sel   = (NUM_DIGITS'(1) << nxt_idx) ^ SEL_OFF;
    show_last  = (state == SHOW)  && (cnt == CW'(DWELL_CYCLES));
    blank_last = (state == BLANK) && (cnt == CW'(BLANK_LAST));
    adv        = ((state == IDLE) && NO_BLANK) || blank_last || (show_last && NO_BLANK);
  end

  // FSM, counter and output registers.
  always_ff @(posedge CLK) begin
    if (RST || !bus.scan_en) begin
      state   <= IDLE;
      cnt     <= '0;
      idx_q   <= IDX_LAST;
      seg_q   <= SEG_OFF;
      sel_q   <= SEL_OFF;
      fd_q    <= 1'b0;
      first_q <= 1'b1;
    end else if (adv) begin
      cnt  <= '0;
      fd_q <= 1'b0;
      if (any_en) begin
        state   <= SHOW;
        idx_q   <= nxt_idx;
        seg_q   <= show_seg;
        sel_q   <= show_sel;
        fd_q    <= wrapped && !first_q;
        first_q <= 1'b0;
      end else begin
        // Nothing enabled: sit blank and retry at the end of each blank period.
        state <= BLANK;
        seg_q <= SEG_OFF;
        sel_q <= SEL_OFF;
      end
    end else if (state == IDLE || show_last) begin
      state <= BLANK;
      cnt   <= '0;
      seg_q <= SEG_OFF;
      sel_q <= SEL_OFF;
      fd_q  <= 1'b0;
    end else begin
      cnt  <= cnt + CW'(1);
      fd_q <= 1'b0;
    end
  end

  assign bus.Seg_Out    = seg_q;
  assign bus.Sel_Out    = sel_q;
  assign bus.digit_idx  = idx_q;
  assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan_multi.sv
// Scoreboard bench for seg_scan_multi: one instance with blanking (2 cycles),
// one without; 4 digits, dwell of 10 cycles, both buses active-low.
module tb_seg_scan_multi;

  typedef struct packed {
    logic [3:0] sel;
    logic [7:0] seg;
    logic [1:0] idx;
    logic       fd;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seg_scan_multi_if #(.NUM_DIGITS(4), .SEG_W(8)) bus_a ();
  seg_scan_multi_if #(.NUM_DIGITS(4), .SEG_W(8)) bus_b ();

  seg_scan_multi #(
    .NUM_DIGITS(4), .SEG_W(8), .DWELL_CYCLES(9), .BLANK_CYCLES(2),
    .SEL_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1)
  ) dut_a (.CLK(clk), .RST(rst), .bus(bus_a));

  seg_scan_multi #(
    .NUM_DIGITS(4), .SEG_W(8), .DWELL_CYCLES(9), .BLANK_CYCLES(0),
    .SEL_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1)
  ) dut_b (.CLK(clk), .RST(rst), .bus(bus_b));

  exp_t qa[$];
  exp_t qb[$];
  int   errors = 0;
  int   checks = 0;

  function automatic exp_t mk(input logic [3:0] sel, input logic [7:0] seg,
                              input logic [1:0] idx, input logic fd);
    exp_t e;
    e.sel = sel; e.seg = seg; e.idx = idx; e.fd = fd;
    return e;
  endfunction

  // Queue the expected outputs after the coming posedge, then move to the next negedge.
  task automatic cyc(input bit which_b, input exp_t e);
    if (which_b) qb.push_back(e);
    else         qa.push_back(e);
    @(negedge clk);
  endtask

  task automatic off(input bit which_b, input int n, input logic [1:0] idx);
    repeat (n) cyc(which_b, mk(4'hF, 8'hFF, idx, 1'b0));
  endtask

  // n cycles of digit d lit with the active-high code; fd only on the first one.
  task automatic show(input bit which_b, input int d, input logic [7:0] code,
                      input logic fd, input int n);
    logic [3:0] one;
    one = 4'b0001;
    for (int i = 0; i < n; i++)
      cyc(which_b, mk(~(one << d), ~code, 2'(d), fd && (i == 0)));
  endtask

  task automatic compare(input string nm, input exp_t got, input exp_t e);
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL %s t=%0t got sel=%b seg=%h idx=%0d fd=%b, expected sel=%b seg=%h idx=%0d fd=%b",
               nm, $time, got.sel, got.seg, got.idx, got.fd, e.sel, e.seg, e.idx, e.fd);
    end
  endtask

  // Monitor: compare each DUT against its queue shortly after every posedge.
  initial begin
    exp_t got;
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (qa.size() > 0) begin
        e   = qa.pop_front();
        got = {bus_a.Sel_Out, bus_a.Seg_Out, bus_a.digit_idx, bus_a.frame_done};
        compare("dut_a", got, e);
      end
      if (qb.size() > 0) begin
        e   = qb.pop_front();
        got = {bus_b.Sel_Out, bus_b.Seg_Out, bus_b.digit_idx, bus_b.frame_done};
        compare("dut_b", got, e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  localparam bit A = 1'b0;
  localparam bit B = 1'b1;

  initial begin
    bus_a.scan_en = 1'b0; bus_a.digit_en = 4'b1111; bus_a.seg_data_in = 32'h44332211;
    bus_b.scan_en = 1'b0; bus_b.digit_en = 4'b1111; bus_b.seg_data_in = 32'h44332211;
    @(negedge clk);

    // Reset, then idle with scanning disabled.
    off(A, 2, 2'd3);
    rst = 1'b0;
    off(A, 1, 2'd3);

    // Basic scan: frame_done only when digit 0 returns.
    bus_a.scan_en = 1'b1;
    off(A, 2, 2'd3); show(A, 0, 8'h11, 1'b0, 10);
    off(A, 2, 2'd0); show(A, 1, 8'h22, 1'b0, 10);
    off(A, 2, 2'd1); show(A, 2, 8'h33, 1'b0, 10);
    off(A, 2, 2'd2); show(A, 3, 8'h44, 1'b0, 10);
    off(A, 2, 2'd3); show(A, 0, 8'h11, 1'b1, 10);
    off(A, 2, 2'd0);

    // Code change mid-SHOW shows up only at the next SHOW of that digit.
    show(A, 1, 8'h22, 1'b0, 5);
    bus_a.seg_data_in[15:8] = 8'h5A;
    show(A, 1, 8'h22, 1'b0, 5);
    off(A, 2, 2'd1); show(A, 2, 8'h33, 1'b0, 10);
    off(A, 2, 2'd2); show(A, 3, 8'h44, 1'b0, 10);
    off(A, 2, 2'd3); show(A, 0, 8'h11, 1'b1, 10);
    off(A, 2, 2'd0); show(A, 1, 8'h5A, 1'b0, 3);

    // Abort mid-SHOW.
    bus_a.scan_en = 1'b0;
    off(A, 2, 2'd3);

    // Skip: digits 1 and 3 only.
    bus_a.seg_data_in[15:8] = 8'h22;
    bus_a.digit_en = 4'b1010;
    bus_a.scan_en  = 1'b1;
    off(A, 2, 2'd3); show(A, 1, 8'h22, 1'b0, 10);
    off(A, 2, 2'd1); show(A, 3, 8'h44, 1'b0, 10);
    off(A, 2, 2'd3); show(A, 1, 8'h22, 1'b1, 10);
    off(A, 2, 2'd1); show(A, 3, 8'h44, 1'b0, 10);

    // All disabled mid-SHOW: dwell completes, then blank until a digit is enabled.
    off(A, 2, 2'd3); show(A, 1, 8'h22, 1'b1, 5);
    bus_a.digit_en = 4'b0000;
    show(A, 1, 8'h22, 1'b0, 5);
    off(A, 6, 2'd1);
    bus_a.digit_en = 4'b0001;
    show(A, 0, 8'h11, 1'b1, 10);
    off(A, 2, 2'd0); show(A, 0, 8'h11, 1'b1, 10);

    // Reset mid-BLANK.
    off(A, 1, 2'd0);
    rst = 1'b1;
    off(A, 1, 2'd3);
    rst = 1'b0;
    bus_a.scan_en = 1'b0;
    off(A, 1, 2'd3);

    // No blanking: back-to-back SHOWs straight out of IDLE.
    bus_b.scan_en = 1'b1;
    show(B, 0, 8'h11, 1'b0, 10); show(B, 1, 8'h22, 1'b0, 10);
    show(B, 2, 8'h33, 1'b0, 10); show(B, 3, 8'h44, 1'b0, 10);
    show(B, 0, 8'h11, 1'b1, 10);
    bus_b.scan_en = 1'b0;
    off(B, 1, 2'd3);

    // Single digit reselects itself each dwell.
    bus_b.digit_en = 4'b0100;
    bus_b.scan_en  = 1'b1;
    show(B, 2, 8'h33, 1'b0, 10); show(B, 2, 8'h33, 1'b1, 10);
    show(B, 2, 8'h33, 1'b1, 5);
    bus_b.digit_en = 4'b0000;
    show(B, 2, 8'h33, 1'b0, 5);
    off(B, 3, 2'd2);
    bus_b.digit_en = 4'b0001;
    show(B, 0, 8'h11, 1'b1, 10);

    @(posedge clk);
    #3;
    checks++;
    if (qa.size() + qb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", qa.size() + qb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
